bus_bridge_slave: RTL and testbench

BUS_BRIDGE_SLAVE -- requirements
Module: bus_bridge_slave

---
 rtl/bus_pkg.sv | 27 ++
 rtl/bb_fifo.sv | 76 +++++++
 rtl/bus_bridge_slave.sv | 205 ++++++++++++++++++++
 tb/tb_bus_bridge_slave.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg -- shared definitions for the serial bus bridge slave.
//   Default bus widths and FIFO depth, the bridge control-state enum, and the
//   outbound request record {write, addr, data}. The record is laid out at
//   the default widths; the bridge packs its FIFO entries in the same field
//   order, so a default-width FIFO word maps directly onto bb_req_t.
package bus_pkg;

  localparam int BB_ADDR_W = 12;
  localparam int BB_DATA_W = 8;
  localparam int BB_FIFO_D = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_ENQ,
    ST_WAIT_RESP,
    ST_RDATA
  } bb_state_e;

  typedef struct packed {
    logic                 write;
    logic [BB_ADDR_W-1:0] addr;
    logic [BB_DATA_W-1:0] data;
  } bb_req_t;

endpackage

// File: rtl/bb_fifo.sv
// bb_fifo -- synchronous first-in first-out buffer for bridge requests.
//   clk, rst : clock and synchronous active-high reset (empties the buffer)
//   push     : write wdata; accepted when not full, or when full and a pop
//              happens in the same cycle
//   wdata    : entry to store
//   pop      : remove head entry; ignored when empty
//   rdata    : current head entry (meaningful only when empty=0)
//   full     : DEPTH entries held
//   empty    : no entries held
//   count    : number of entries held (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module bb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a full buffer may still
  // accept a push while popping.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; occupancy is tracked by the reset pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/bus_bridge_slave.sv
// bus_bridge_slave -- serial bus slave that turns master frames into parallel
// requests for a remote side, with posted writes and a read-return path.
//   clk, rst              : clock, synchronous active-high reset
//   mode                  : frame type (1=write, 0=read), taken with address bit 0
//   wr_bus, master_valid  : serial address / write-data bit from master
//   slave_ready           : bridge accepts the wr_bus bit this cycle
//   rd_bus, slave_valid   : serial read-data bit to master (rd_bus=0 when idle)
//   master_ready          : master accepts the rd_bus bit
//   split                 : read parked awaiting remote data (BB_SPLIT_EN only)
//   req_valid/req_ready   : request FIFO head handshake to remote side
//   req_write/addr/data   : request fields (data is 0 for reads; all 0 when empty)
//   resp_valid, resp_data : single-cycle remote read return
// Frames are LSB first: ADDR_WIDTH address bits, then DATA_WIDTH data bits for
// writes. Read data returns LSB first. ADDR_WIDTH and DATA_WIDTH must be >= 2.
// Build option: define BB_SPLIT_EN to drive split while a read waits for the
// remote side; otherwise split is tied low and the bus is held.
module bus_bridge_slave
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = BB_ADDR_W,
  parameter int DATA_WIDTH = BB_DATA_W,
  parameter int FIFO_DEPTH = BB_FIFO_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  wr_bus,
  input  logic                  master_valid,
  output logic                  slave_ready,
  output logic                  rd_bus,
  output logic                  slave_valid,
  input  logic                  master_ready,
  output logic                  split,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_write,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_data,
  input  logic                  resp_valid,
  input  logic [DATA_WIDTH-1:0] resp_data
);

  localparam int MAX_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W  = $clog2(MAX_W);
  localparam int AIDX_W = $clog2(ADDR_WIDTH);
  localparam int DIDX_W = $clog2(DATA_WIDTH);
  localparam int REQ_W  = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  bb_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [REQ_W-1:0]      fifo_wdata;
  logic [REQ_W-1:0]      fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCNT_W-1:0]     fifo_count;

  logic                  bit_in;
  logic                  bit_out;
  logic                  enq_ok;

  assign bit_in  = master_valid && slave_ready;
  assign bit_out = slave_valid && master_ready;

  // The push lands when there is room now or the head leaves this cycle.
  assign fifo_pop = req_ready && !fifo_empty;
  assign enq_ok   = (fifo_count != FCNT_W'(FIFO_DEPTH)) || fifo_pop;

  // Reads carry no data towards the remote side.
  assign fifo_wdata = {mode_q, addr_q, (mode_q ? wdata_q : {DATA_WIDTH{1'b0}})};

  // Gated by rst so the bridge stays closed for every cycle reset is held.
  always_comb begin
    slave_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE:           slave_ready = !fifo_full;
        ST_ADDR, ST_WDATA: slave_ready = 1'b1;
        default:           slave_ready = 1'b0;
      endcase
    end
  end

  assign slave_valid = (state_q == ST_RDATA);
  assign rd_bus      = slave_valid && rdata_q[cnt_q[DIDX_W-1:0]];

  assign req_valid = !fifo_empty;
  assign {req_write, req_addr, req_data} = fifo_empty ? {REQ_W{1'b0}} : fifo_rdata;

`ifdef BB_SPLIT_EN
  assign split = (state_q == ST_WAIT_RESP);
`else
  assign split = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    fifo_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The first accepted bit is address bit 0 and fixes the frame type.
        if (bit_in) begin
          addr_d    = '0;
          addr_d[0] = wr_bus;
          mode_d    = mode;
          cnt_d     = CNT_W'(1);
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bit_in) begin
          addr_d[cnt_q[AIDX_W-1:0]] = wr_bus;
          if (cnt_q == CNT_W'(ADDR_WIDTH-1)) begin
            cnt_d   = '0;
            state_d = mode_q ? ST_WDATA : ST_ENQ;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WDATA: begin
        if (bit_in) begin
          wdata_d[cnt_q[DIDX_W-1:0]] = wr_bus;
          if (cnt_q == CNT_W'(DATA_WIDTH-1)) begin
            cnt_d   = '0;
            state_d = ST_ENQ;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ENQ: begin
        // Writes are posted: the frame ends as soon as the request is queued.
        fifo_push = 1'b1;
        if (enq_ok) state_d = mode_q ? ST_IDLE : ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (resp_valid) begin
          rdata_d = resp_data;
          cnt_d   = '0;
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (bit_out) begin
          if (cnt_q == CNT_W'(DATA_WIDTH-1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state register: reset returns to IDLE with counters cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Shift/capture registers: data only, qualified by the control state.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  bb_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_bus_bridge_slave.sv
// tb_bus_bridge_slave -- scoreboard bench for bus_bridge_slave.
// The master driver serialises frames and queues the request each frame must
// produce; a remote-side responder answers read requests; a monitor compares
// every request handshake and every read-data bit against the queues.
module tb_bus_bridge_slave;
  import bus_pkg::*;

  localparam int AW = BB_ADDR_W;
  localparam int DW = BB_DATA_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          wr_bus;
  logic          master_valid;
  logic          slave_ready;
  logic          rd_bus;
  logic          slave_valid;
  logic          master_ready;
  logic          split;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          resp_valid;
  logic [DW-1:0] resp_data;

  always #5 clk = ~clk;

  bus_bridge_slave dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .wr_bus       (wr_bus),
    .master_valid (master_valid),
    .slave_ready  (slave_ready),
    .rd_bus       (rd_bus),
    .slave_valid  (slave_valid),
    .master_ready (master_ready),
    .split        (split),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data)
  );

  int      checks   = 0;
  int      failures = 0;
  bb_req_t exp_req_q[$];
  bit      exp_bit_q[$];
  int      rr_en = 0;           // 0: remote never takes requests, 1: random
  int      rd_seen = 0;
  bit      read_outstanding = 1'b0;
  int      resp_cnt = -1;
  bit      resp_fixed = 1'b0;
  logic [DW-1:0] resp_fixed_data = '0;
  int      resp_fixed_delay = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Remote side + monitor, all decisions made on the falling edge.
  always @(negedge clk) begin
    bb_req_t e;
    bit      b;
    logic [DW-1:0] d;
    req_ready    = (rr_en != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    master_ready = ($urandom_range(0, 3) != 0);
    resp_valid   = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        d = resp_fixed ? resp_fixed_data : DW'($urandom);
        resp_valid = 1'b1;
        resp_data  = d;
        for (int i = 0; i < DW; i++) exp_bit_q.push_back(d[i]);
        resp_cnt = -1;
      end
    end else if (!read_outstanding && $urandom_range(0, 7) == 0) begin
      resp_valid = 1'b1;          // stray pulse: must be ignored
      resp_data  = DW'($urandom);
    end
    if (!rst) begin
      if (req_valid && req_ready) begin
        if (exp_req_q.size() == 0) begin
          chk("req_unexpected", {11'd0, req_write, req_addr, req_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_req_q.pop_front();
          chk("req", {11'd0, req_write, req_addr, req_data}, {11'd0, e});
          if (!e.write) resp_cnt = resp_fixed ? resp_fixed_delay : $urandom_range(1, 6);
        end
      end
      if (slave_valid && master_ready) begin
        if (exp_bit_q.size() == 0) begin
          chk("rd_bit_unexpected", {31'd0, rd_bus}, 32'hFFFF_FFFF);
        end else begin
          b = exp_bit_q.pop_front();
          chk("rd_bit", {31'd0, rd_bus}, {31'd0, b});
        end
        rd_seen++;
      end
      if (!slave_valid) chk("rd_bus_idle", {31'd0, rd_bus}, 32'd0);
`ifdef BB_SPLIT_EN
      if (!read_outstanding) chk("split_idle", {31'd0, split}, 32'd0);
`else
      chk("split_off", {31'd0, split}, 32'd0);
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; returns on the falling edge after the transfer.
  task automatic send_bit(input logic b, input logic m);
    int n = 0;
    master_valid = 1'b1;
    wr_bus       = b;
    mode         = m;
    while (!slave_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!slave_ready) begin
      chk("send_bit_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
    end
    master_valid = 1'b0;
    wr_bus       = 1'b0;
  endtask

  task automatic send_frame(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int gap_pos, input int gap_len, input bit rgap,
                            input int stop_after);
    int sent = 0;
    for (int i = 0; i < AW; i++) begin
      if (i == gap_pos) idle(gap_len);
      if (rgap && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send_bit(a[i], w);
      sent++;
      if (sent == stop_after) return;
    end
    if (w) begin
      for (int i = 0; i < DW; i++) begin
        if (rgap && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send_bit(d[i], w);
        sent++;
        if (sent == stop_after) return;
      end
    end
    exp_req_q.push_back(bb_req_t'{write: w, addr: a, data: (w ? d : '0)});
  endtask

  task automatic do_read(input logic [AW-1:0] a, input bit rgap);
    int target;
    int n = 0;
    read_outstanding = 1'b1;
    target = rd_seen + DW;
    send_frame(1'b0, a, '0, -1, 0, rgap, -1);
    while (rd_seen < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("read_complete", {31'd0, rd_seen >= target}, 32'd1);
    read_outstanding = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_req_q.size() != 0 || exp_bit_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_req", exp_req_q.size(), 0);
    chk("drain_bits", exp_bit_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_slave_ready"}, {31'd0, slave_ready}, 0);
    chk({tag, "_slave_valid"}, {31'd0, slave_valid}, 0);
    chk({tag, "_rd_bus"},      {31'd0, rd_bus}, 0);
    chk({tag, "_split"},       {31'd0, split}, 0);
    chk({tag, "_req_valid"},   {31'd0, req_valid}, 0);
    chk({tag, "_req_write"},   {31'd0, req_write}, 0);
    chk({tag, "_req_addr"},    {20'd0, req_addr}, 0);
    chk({tag, "_req_data"},    {24'd0, req_data}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 1'b0; wr_bus = 1'b0; master_valid = 1'b0;
    master_ready = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, slave_ready}, 1);

    // Write 0x0A5 / 0x3C with the remote side stalled: head is observable.
    send_frame(1'b1, 12'h0A5, 8'h3C, -1, 0, 0, -1);
    @(negedge clk);
    chk("w1_req_valid", {31'd0, req_valid}, 1);
    chk("w1_req_write", {31'd0, req_write}, 1);
    chk("w1_req_addr", {20'd0, req_addr}, 32'h0A5);
    chk("w1_req_data", {24'd0, req_data}, 32'h3C);

    // Three more writes fill the buffer; a fifth frame must wait for a pop.
    for (int k = 0; k < 3; k++)
      send_frame(1'b1, AW'($urandom), DW'($urandom), -1, 0, 1, -1);
    @(negedge clk);
    chk("full_blocks_ready", {31'd0, slave_ready}, 0);
    idle(5);
    chk("full_still_blocked", {31'd0, slave_ready}, 0);
    chk("full_head_addr", {20'd0, req_addr}, 32'h0A5);
    rr_en = 1;
    send_frame(1'b1, 12'h123, 8'hE7, -1, 0, 0, -1);
    drain();

    // Read 0x800 answered with 0x5A three cycles after the handshake.
    resp_fixed = 1'b1; resp_fixed_data = 8'h5A; resp_fixed_delay = 3;
    do_read(12'h800, 0);
    resp_fixed = 1'b0;
    @(negedge clk);
    chk("idle_after_read", {31'd0, slave_ready}, 1);

    // master_valid withdrawn for 10 cycles after address bit 5.
    send_frame(1'b1, 12'hB6D, 8'h81, 6, 10, 0, -1);
    do_read(12'h5C3, 0);
    drain();

    // Reset during data bit 3 with a write still queued.
    rr_en = 0;
    idle(2);
    send_frame(1'b1, 12'h777, 8'h11, -1, 0, 0, -1);
    send_frame(1'b1, 12'h3F0, 8'hAB, -1, 0, 0, AW + 3);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    exp_req_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, slave_ready}, 1);
    chk("midrst_fifo_empty", {31'd0, req_valid}, 0);
    rr_en = 1;
    send_frame(1'b1, 12'h9E1, 8'h5F, -1, 0, 0, -1);
    do_read(12'h042, 0);
    drain();

    // Randomised mix of writes and reads, with master and remote stalls.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) do_read(AW'($urandom), 1);
      else send_frame(1'b1, AW'($urandom), DW'($urandom), -1, 0, 1, -1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
